// File: rtl/tty_pkg.sv
// Shared types and constants for the serial character input port.
package tty_pkg;

  localparam int TTY_CHAR_W     = 7;
  localparam int TTY_FRAME_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HI
  } tty_in_state_e;

endpackage

// File: rtl/tty_in_fifo.sv
// First-word fall-through character FIFO with a sticky overflow flag.
module tty_in_fifo
  import tty_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = TTY_CHAR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, pop_ok, push_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign valid = !empty;
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      // A new overflow wins over a clear in the same cycle.
      if (push && !push_ok) ovf <= 1'b1;
      else if (clr_ovf)     ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/tty_in.sv
// 8N1 serial receiver feeding a small character FIFO.
// Optional TTY_IN_ECHO_EN adds echo_o/echo_we_o mirroring every accepted character.
module tty_in
  import tty_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_i,
  input  logic                  rd_i,
  output logic [TTY_CHAR_W-1:0] data_o,
  output logic                  valid_o,
  output logic                  ovf_o,
  input  logic                  clr_ovf_i,
  output logic                  frame_err_o
`ifdef TTY_IN_ECHO_EN
  ,
  output logic [TTY_CHAR_W-1:0] echo_o,
  output logic                  echo_we_o
`endif
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(TTY_FRAME_BITS - 1);

  tty_in_state_e             state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [2:0]                bit_idx, bit_n;
  logic [TTY_FRAME_BITS-1:0] shift, shift_n;
  logic                      rx_meta, rxs;
  logic                      push, ferr_n;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_n;
      shift       <= shift_n;
      frame_err_o <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    push    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          state_n = ST_START;
          cnt_n   = HALF_LD;
        end
      end
      ST_START: begin
        // Mid-start-bit recheck rejects short glitches.
        if (cnt == '0) begin
          if (rxs) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            cnt_n   = FULL_LD;
            bit_n   = '0;
          end
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          shift_n = {rxs, shift[TTY_FRAME_BITS-1:1]};
          cnt_n   = FULL_LD;
          if (bit_idx == LAST_BIT) state_n = ST_STOP;
          else                     bit_n   = bit_idx + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt == '0) begin
          if (rxs) begin
            push    = 1'b1;
            state_n = ST_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        // Holding here keeps a long break to a single error pulse.
        if (rxs) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  tty_in_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TTY_CHAR_W)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (push),
    .wdata   (shift[TTY_CHAR_W-1:0]),
    .pop     (rd_i),
    .clr_ovf (clr_ovf_i),
    .rdata   (data_o),
    .valid   (valid_o),
    .ovf     (ovf_o)
  );

`ifdef TTY_IN_ECHO_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      echo_o    <= '0;
      echo_we_o <= 1'b0;
    end else begin
      echo_we_o <= push;
      if (push) echo_o <= shift[TTY_CHAR_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_tty_in.sv
// Self-checking bench for tty_in (CLK_DIV=4, FIFO_DEPTH=4).
module tb_tty_in;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rd = 1'b0, clr = 1'b0;
  logic [6:0] data;
  logic       valid, ovf, ferr;
`ifdef TTY_IN_ECHO_EN
  logic [6:0] echo;
  logic       echo_we;
`endif

  tty_in #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .rd_i        (rd),
    .data_o      (data),
    .valid_o     (valid),
    .ovf_o       (ovf),
    .clr_ovf_i   (clr),
    .frame_err_o (ferr)
`ifdef TTY_IN_ECHO_EN
    ,
    .echo_o      (echo),
    .echo_we_o   (echo_we)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int ferr_cnt = 0, echo_cnt = 0;
  logic [6:0] echo_last = '0;
  logic [6:0] q[$];
  logic       ovf_m;

  always @(posedge clk) begin
    #2;
    if (ferr) ferr_cnt++;
`ifdef TTY_IN_ECHO_EN
    if (echo_we) begin
      echo_cnt++;
      echo_last = echo;
    end
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first, stop; returns at the negedge of the stop-sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (q.size() < DEPTH) q.push_back(b[6:0]);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic pop_chk(input string name);
    check({name, ".valid_pre"}, valid, q.size() > 0);
    if (q.size() > 0) check({name, ".data"}, data, q[0]);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check({name, ".valid_post"}, valid, q.size() > 0);
  endtask

  typedef struct {
    logic [7:0] ch;
    logic       stop;
    logic       exp_valid;
    logic [6:0] exp_head;
    logic       exp_ovf;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int f0, e0, nf, np;
    logic [7:0] b;
    logic       s;

    vecs[0] = '{8'h31, 1'b1, 1'b1, 7'h31, 1'b0, 0};
    vecs[1] = '{8'h32, 1'b1, 1'b1, 7'h31, 1'b0, 0};
    vecs[2] = '{8'h33, 1'b1, 1'b1, 7'h31, 1'b0, 0};
    vecs[3] = '{8'h34, 1'b1, 1'b1, 7'h31, 1'b0, 0};
    vecs[4] = '{8'h35, 1'b1, 1'b1, 7'h31, 1'b1, 0};
    vecs[5] = '{8'h77, 1'b0, 1'b1, 7'h31, 1'b1, 1};

    idle(3);
    check("reset.data", data, 0);
    check("reset.valid", valid, 0);
    check("reset.ovf", ovf, 0);
    check("reset.ferr", ferr, 0);
    rst = 1'b0;
    idle(2);

    // Single character, exact landing cycle
    send_frame(8'h41, 1'b1);
    check("single.valid_at_stop", valid, 0);
    @(negedge clk);
    check("single.valid_after", valid, 1);
    check("single.data", data, 7'h41);
    q.push_back(7'h41);
    pop_chk("single.pop");

    // MSB strip and ordering, back-to-back frames
    send_frame(8'hC8, 1'b1);
    send_frame(8'h69, 1'b1);
    model_frame(8'hC8, 1'b1);
    model_frame(8'h69, 1'b1);
    idle(4);
    pop_chk("b2b.pop0");
    pop_chk("b2b.pop1");

    // Overflow table
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt;
      send_frame(vecs[i].ch, vecs[i].stop);
      idle(5);
      check($sformatf("tbl%0d.valid", i), valid, vecs[i].exp_valid);
      check($sformatf("tbl%0d.head", i), data, vecs[i].exp_head);
      check($sformatf("tbl%0d.ovf", i), ovf, vecs[i].exp_ovf);
      check($sformatf("tbl%0d.ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
    end
    q = '{7'h31, 7'h32, 7'h33, 7'h34};

    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("ovf.cleared", ovf, 0);
    send_frame(8'h36, 1'b1);
    idle(2);
    check("ovf.reset_by_6th", ovf, 1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("ovf.cleared2", ovf, 0);

    // Pop in the cycle a push lands on a full FIFO
    send_frame(8'h37, 1'b1);
    check("fullpop.head", data, 7'h31);
    rd = 1'b1; @(negedge clk); rd = 1'b0;
    check("fullpop.ovf", ovf, 0);
    q = '{7'h32, 7'h33, 7'h34, 7'h37};
    for (int i = 0; i < 5; i++) pop_chk($sformatf("fullpop.drain%0d", i));
    check("fullpop.ovf_end", ovf, 0);

    // Glitch
    f0 = ferr_cnt;
    rx = 1'b0; @(negedge clk); rx = 1'b1;
    idle(12);
    check("glitch.valid", valid, 0);
    check("glitch.ferr", ferr_cnt - f0, 0);

    // Break: bad stop, line held low
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    idle(50);
    rx = 1'b1;
    idle(6);
    check("break.ferr", ferr_cnt - f0, 1);
    check("break.valid", valid, 0);

    // Reset during DATA
    send_frame(8'h22, 1'b1);
    idle(2);
    check("rst.preload", valid, 1);
    rx = 1'b0; idle(CLK_DIV);
    rx = 1'b1; idle(2 * CLK_DIV);
    rst = 1'b1;
    #1;
    check("rst.data", data, 0);
    check("rst.valid", valid, 0);
    check("rst.ovf", ovf, 0);
    check("rst.ferr", ferr, 0);
    idle(3);
    rst = 1'b0;
    idle(4);
    e0 = echo_cnt;
    send_frame(8'h5A, 1'b1);
    idle(3);
    check("rst.valid_5a", valid, 1);
    check("rst.data_5a", data, 7'h5A);
`ifdef TTY_IN_ECHO_EN
    check("echo.count", echo_cnt - e0, 1);
    check("echo.data", echo_last, 7'h5A);
`endif
    q = '{7'h5A};
    pop_chk("rst.pop");

    // Randomized frames against queue model
    ovf_m = 1'b0;
    nf = 0;
    for (int it = 0; it < 24; it++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 7) != 0);
      f0 = ferr_cnt;
      send_frame(b, s);
      model_frame(b, s);
      nf = s ? 0 : 1;
      idle(5);
      check($sformatf("rnd%0d.valid", it), valid, q.size() > 0);
      if (q.size() > 0) check($sformatf("rnd%0d.head", it), data, q[0]);
      check($sformatf("rnd%0d.ovf", it), ovf, ovf_m);
      check($sformatf("rnd%0d.ferr", it), ferr_cnt - f0, nf);
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) pop_chk($sformatf("rnd%0d.pop%0d", it, k));
      if ($urandom_range(0, 3) == 0) begin
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        ovf_m = 1'b0;
        check($sformatf("rnd%0d.clr", it), ovf, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
